// File: rtl/bcd_button_counter.sv
// -----------------------------------------------------------------------------
// bcd_button_counter
//   Turns two raw active-low push-buttons (up/down) into a debounced,
//   wrap-around count 0..MAX_COUNT. It drives the 7-segment decoder directly.
//   Each button passes through a 2-flop synchroniser, then a debouncer, then a
//   falling-edge detector that makes a registered one-cycle press pulse.
//   The carry and borrow pulses let a second digit be chained.
//
// Ports
//   clk         in   1      system clock, rising edge
//   rst_n       in   1      asynchronous active-low reset
//   btn_up_n    in   1      raw up button, active-low, asynchronous
//   btn_down_n  in   1      raw down button, active-low, asynchronous
//   load        in   1      synchronous load strobe, active-high
//   load_value  in   WIDTH  value to load, clamped to MAX_COUNT
//   digit       out  WIDTH  current count, registered
//   carry       out  1      one-cycle pulse on the MAX_COUNT->0 wrap
//   borrow      out  1      one-cycle pulse on the 0->MAX_COUNT wrap
// -----------------------------------------------------------------------------
module bcd_button_counter #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned MAX_COUNT       = 9,
    parameter int unsigned WIDTH           = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_up_n,
    input  logic             btn_down_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] digit,
    output logic             carry,
    output logic             borrow
);

    localparam int unsigned      CntW    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0]  CntLast = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH-1:0] MaxVal  = WIDTH'(MAX_COUNT);

    // Button index 0 = up, 1 = down. All button levels are active-low.
    logic [1:0]      raw_n;
    logic [1:0]      sync1_q, sync2_q;
    logic [1:0]      stable_q, stable_prev_q;
    logic [1:0]      press_q;
    logic [CntW-1:0] cnt_q [2];

    assign raw_n = {btn_down_n, btn_up_n};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q       <= 2'b11;
            sync2_q       <= 2'b11;
            stable_q      <= 2'b11;
            stable_prev_q <= 2'b11;
            press_q       <= 2'b00;
            cnt_q[0]      <= '0;
            cnt_q[1]      <= '0;
        end else begin
            sync1_q       <= raw_n;
            sync2_q       <= sync1_q;
            stable_prev_q <= stable_q;
            // Only a released->pressed transition of the debounced level pulses.
            press_q       <= stable_prev_q & ~stable_q;
            for (int b = 0; b < 2; b++) begin
                if (sync2_q[b] == stable_q[b]) begin
                    cnt_q[b] <= '0;
                end else if (cnt_q[b] == CntLast) begin
                    // DEBOUNCE_CYCLES consecutive differing samples: accept the change.
                    stable_q[b] <= sync2_q[b];
                    cnt_q[b]    <= '0;
                end else begin
                    cnt_q[b] <= cnt_q[b] + CntW'(1);
                end
            end
        end
    end

    logic [WIDTH-1:0] digit_q, digit_d;
    logic             carry_q, carry_d;
    logic             borrow_q, borrow_d;
    logic             up_pulse, down_pulse;

    assign up_pulse   = press_q[0];
    assign down_pulse = press_q[1];

    always_comb begin
        digit_d  = digit_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        if (load) begin
            digit_d = (load_value > MaxVal) ? MaxVal : load_value;
        end else if (up_pulse && down_pulse) begin
            digit_d = digit_q;
        end else if (up_pulse) begin
            if (digit_q == MaxVal) begin
                digit_d = '0;
                carry_d = 1'b1;
            end else begin
                digit_d = digit_q + WIDTH'(1);
            end
        end else if (down_pulse) begin
            if (digit_q == '0) begin
                digit_d  = MaxVal;
                borrow_d = 1'b1;
            end else begin
                digit_d = digit_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q  <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            digit_q  <= digit_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
        end
    end

    assign digit  = digit_q;
    assign carry  = carry_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_bcd_button_counter.sv
// -----------------------------------------------------------------------------
// tb_bcd_button_counter
//   Self-checking bench for bcd_button_counter with DEBOUNCE_CYCLES=4,
//   MAX_COUNT=9 and WIDTH=4. A reference model checks the DUT on every cycle.
//   The model counts how long each raw button has differed from its accepted
//   level. It then schedules the count effect at a fixed number of edges after
//   the change is accepted. Table-driven load vectors and directed sequences
//   add checks against constants.
// -----------------------------------------------------------------------------
module tb_bcd_button_counter;

    localparam int unsigned D    = 4;
    localparam int unsigned MAXC = 9;
    localparam int unsigned W    = 4;
    // The accepted press reaches the digit this many edges after the Dth low sample.
    localparam int          LAT  = 4;

    logic         clk        = 1'b0;
    logic         rst_n      = 1'b0;
    logic         btn_up_n   = 1'b1;
    logic         btn_down_n = 1'b1;
    logic         load       = 1'b0;
    logic [W-1:0] load_value = '0;
    logic [W-1:0] digit;
    logic         carry;
    logic         borrow;

    bcd_button_counter #(
        .DEBOUNCE_CYCLES (D),
        .MAX_COUNT       (MAXC),
        .WIDTH           (W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_up_n   (btn_up_n),
        .btn_down_n (btn_down_n),
        .load       (load),
        .load_value (load_value),
        .digit      (digit),
        .carry      (carry),
        .borrow     (borrow)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int m_digit;
    bit m_carry;
    bit m_borrow;
    bit m_stable [2];
    int m_run [2];
    bit m_raw [2];
    bit m_up;
    bit m_dn;
    int edge_n = 0;
    int up_due[$];
    int dn_due[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_digit  = 0;
            m_carry  = 0;
            m_borrow = 0;
            for (int b = 0; b < 2; b++) begin
                m_stable[b] = 1'b1;
                m_run[b]    = 0;
            end
            up_due.delete();
            dn_due.delete();
        end else begin
            edge_n = edge_n + 1;
            m_up = (up_due.size() > 0) && (up_due[0] == edge_n);
            if (m_up) void'(up_due.pop_front());
            m_dn = (dn_due.size() > 0) && (dn_due[0] == edge_n);
            if (m_dn) void'(dn_due.pop_front());

            m_carry  = 0;
            m_borrow = 0;
            if (load) begin
                m_digit = (int'(load_value) > MAXC) ? MAXC : int'(load_value);
            end else if (m_up && m_dn) begin
                m_digit = m_digit;
            end else if (m_up) begin
                if (m_digit == MAXC) begin
                    m_digit = 0;
                    m_carry = 1;
                end else begin
                    m_digit = m_digit + 1;
                end
            end else if (m_dn) begin
                if (m_digit == 0) begin
                    m_digit  = MAXC;
                    m_borrow = 1;
                end else begin
                    m_digit = m_digit - 1;
                end
            end

            m_raw[0] = btn_up_n;
            m_raw[1] = btn_down_n;
            for (int b = 0; b < 2; b++) begin
                if (m_raw[b] != m_stable[b]) begin
                    m_run[b] = m_run[b] + 1;
                    if (m_run[b] == D) begin
                        m_stable[b] = m_raw[b];
                        m_run[b]    = 0;
                        if (!m_raw[b]) begin
                            if (b == 0) up_due.push_back(edge_n + LAT);
                            else        dn_due.push_back(edge_n + LAT);
                        end
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
        end
    end

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;
    bit sb_en = 0;
    int carry_seen  = 0;
    int borrow_seen = 0;

    task automatic check(input string name, input int act, input int exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock edge, then compare against the model 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
        if (carry)  carry_seen  = carry_seen + 1;
        if (borrow) borrow_seen = borrow_seen + 1;
        if (sb_en && rst_n) begin
            check("sb_digit", int'(digit), m_digit);
            check("sb_carry", int'(carry), int'(m_carry));
            check("sb_borrow", int'(borrow), int'(m_borrow));
            check("sb_range_excl", int'(digit <= MAXC && !(carry && borrow)), 1);
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_load(input int v);
        load       = 1'b1;
        load_value = W'(v);
        step();
        load       = 1'b0;
    endtask

    task automatic press_up();
        btn_up_n = 1'b0;
        steps(8);
        btn_up_n = 1'b1;
        steps(8);
    endtask

    task automatic press_down();
        btn_down_n = 1'b0;
        steps(8);
        btn_down_n = 1'b1;
        steps(8);
    endtask

    typedef struct {
        logic [W-1:0] lv;
        int           exp_digit;
    } load_vec_t;

    load_vec_t vecs [8];

    initial begin
        vecs[0] = '{lv: 4'd0,  exp_digit: 0};
        vecs[1] = '{lv: 4'd9,  exp_digit: 9};
        vecs[2] = '{lv: 4'd10, exp_digit: 9};
        vecs[3] = '{lv: 4'd15, exp_digit: 9};
        vecs[4] = '{lv: 4'd3,  exp_digit: 3};
        vecs[5] = '{lv: 4'd7,  exp_digit: 7};
        vecs[6] = '{lv: 4'd12, exp_digit: 9};
        vecs[7] = '{lv: 4'd5,  exp_digit: 5};

        // Reset state
        steps(2);
        check("reset_digit", int'(digit), 0);
        check("reset_carry", int'(carry), 0);
        check("reset_borrow", int'(borrow), 0);
        rst_n = 1'b1;
        sb_en = 1'b1;
        steps(2);

        // Table-driven loads, including the clamp above MAX_COUNT
        for (int i = 0; i < 8; i++) begin
            do_load(int'(vecs[i].lv));
            check("load_digit", int'(digit), vecs[i].exp_digit);
            check("load_no_carry", int'(carry | borrow), 0);
        end

        // Reset in the middle of a debounce discards the press
        btn_up_n = 1'b0;
        steps(4);
        rst_n = 1'b0;
        #1;
        check("midreset_digit", int'(digit), 0);
        check("midreset_flags", int'({carry, borrow}), 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("post_reset_latency", int'(digit), (i >= 7) ? 1 : 0);
        end
        btn_up_n = 1'b1;
        steps(8);

        // A held press steps exactly once, at edge 7
        do_load(0);
        btn_up_n = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            check("hold_latency", int'(digit), (i >= 7) ? 1 : 0);
        end
        btn_up_n = 1'b1;
        steps(8);
        check("release_no_step", int'(digit), 1);

        // Glitches shorter than the debounce window are ignored
        btn_up_n = 1'b0;
        steps(2);
        btn_up_n = 1'b1;
        steps(8);
        check("glitch2", int'(digit), 1);
        for (int g = 0; g < 3; g++) begin
            btn_up_n = 1'b0;
            steps(3);
            btn_up_n = 1'b1;
            step();
        end
        steps(8);
        check("glitch_train", int'(digit), 1);

        // Ten up presses from 0 wrap with a single carry
        do_load(0);
        carry_seen = 0;
        for (int k = 1; k <= 10; k++) begin
            press_up();
            check("up_seq", int'(digit), k % 10);
        end
        check("carry_once", carry_seen, 1);

        // Down from 0 borrows, then loads clamp
        do_load(0);
        borrow_seen = 0;
        press_down();
        check("down_wrap", int'(digit), 9);
        check("borrow_once", borrow_seen, 1);
        do_load(12);
        check("load_clamp", int'(digit), 9);
        do_load(5);
        check("load_5", int'(digit), 5);

        // Both buttons together: no change and no pulses
        carry_seen  = 0;
        borrow_seen = 0;
        btn_up_n    = 1'b0;
        btn_down_n  = 1'b0;
        steps(16);
        check("both_hold", int'(digit), 5);
        check("both_no_pulse", carry_seen + borrow_seen, 0);
        btn_up_n   = 1'b1;
        btn_down_n = 1'b1;
        steps(8);

        // A load on the same edge as the up pulse wins
        btn_up_n = 1'b0;
        steps(7);
        do_load(3);
        check("load_wins", int'(digit), 3);
        steps(4);
        check("load_wins_after", int'(digit), 3);
        btn_up_n = 1'b1;
        steps(8);

        // Randomised stimulus against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 4) == 0) btn_up_n   = ~btn_up_n;
            if ($urandom_range(0, 4) == 0) btn_down_n = ~btn_down_n;
            load       = ($urandom_range(0, 19) == 0);
            load_value = W'($urandom_range(0, 15));
            step();
        end
        load = 1'b0;
        steps(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
